motor_line_sequencer: RTL and testbench

- Owns the shared motor-line resource and decides whether the DSHOT controller or the BLHeli serial passthrough bridge drives the four motor pins.
- Sequences every handover: drains any in-flight DSHOT frame, holds the lines idle-high for a guard time, then enables the bridge.
- On exit, or after passthrough inactivity, it guards the lines again and returns them to DSHOT.
- Runs in the 27 MHz input-clock domain, next to POR/heartbeat logic; all requests and status inputs arrive asynchronously.

---
 rtl/motor_seq_pkg.sv | 42 ++++
 rtl/sync_2ff.sv | 29 ++
 rtl/motor_line_sequencer.sv | 156 +++++++++++++++
 tb/tb_motor_line_sequencer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_seq_pkg.sv
// Shared types and encodings for the motor-line handover sequencer.
package motor_seq_pkg;

    // Raw state encodings, also brought out on the debug pins.
    localparam logic [2:0] ENC_DSHOT    = 3'd0;
    localparam logic [2:0] ENC_DRAIN    = 3'd1;
    localparam logic [2:0] ENC_GUARD_PT = 3'd2;
    localparam logic [2:0] ENC_PASSTHRU = 3'd3;
    localparam logic [2:0] ENC_GUARD_DS = 3'd4;

    typedef enum logic [2:0] {
        ST_DSHOT    = ENC_DSHOT,
        ST_DRAIN    = ENC_DRAIN,
        ST_GUARD_PT = ENC_GUARD_PT,
        ST_PASSTHRU = ENC_PASSTHRU,
        ST_GUARD_DS = ENC_GUARD_DS
    } seq_state_e;

    // Line-control outputs that are a pure function of the state.
    typedef struct packed {
        logic mux_sel;
        logic dshot_enable;
        logic bridge_enable;
        logic hold_high;
    } line_ctrl_t;

    localparam line_ctrl_t LINES_DSHOT = '{mux_sel: 1'b1, dshot_enable: 1'b1, bridge_enable: 1'b0, hold_high: 1'b0};
    localparam line_ctrl_t LINES_DRAIN = '{mux_sel: 1'b1, dshot_enable: 1'b0, bridge_enable: 1'b0, hold_high: 1'b0};
    localparam line_ctrl_t LINES_GUARD = '{mux_sel: 1'b0, dshot_enable: 1'b0, bridge_enable: 1'b0, hold_high: 1'b1};
    localparam line_ctrl_t LINES_PT    = '{mux_sel: 1'b0, dshot_enable: 1'b0, bridge_enable: 1'b1, hold_high: 1'b0};

    // Anything unexpected falls back to holding the lines idle-high.
    function automatic line_ctrl_t decode_lines(input seq_state_e st);
        case (st)
            ST_DSHOT:    return LINES_DSHOT;
            ST_DRAIN:    return LINES_DRAIN;
            ST_PASSTHRU: return LINES_PT;
            default:     return LINES_GUARD;
        endcase
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank for asynchronous level inputs.
module sync_2ff #(
    parameter int unsigned      WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             por_reset_27m,
    input  logic [WIDTH-1:0] i_async,
    output logic [WIDTH-1:0] o_sync
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; reset value matches each input's idle level.
    always_ff @(posedge i_clk or posedge por_reset_27m) begin
        if (por_reset_27m) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            // NOTE: non-blocking so sync_q takes the old meta_q, giving two real stages.
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule

// File: rtl/motor_line_sequencer.sv
// Arbitrates the four motor lines between DSHOT and the BLHeli passthrough bridge,
// with drain, idle-high guard and inactivity timeout on every handover.
module motor_line_sequencer
    import motor_seq_pkg::*;
#(
    parameter int unsigned GUARD_CYCLES     = 27000,
    parameter int unsigned DRAIN_MAX_CYCLES = 2700,
    parameter int unsigned TIMEOUT_CYCLES   = 135000000,
    parameter int unsigned CNT_W            = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       i_clk,
    input  logic       por_reset_27m,
    input  logic       i_req_passthrough,
    input  logic       i_dshot_busy,
    input  logic       i_usb_rx,
    input  logic       i_esc_rx,
    output logic       o_mux_sel,
    output logic       o_dshot_enable,
    output logic       o_bridge_enable,
    output logic       o_hold_high,
    output logic [2:0] o_state,
    output logic       o_timeout_pulse,
    output logic       o_timed_out
);

    localparam logic [CNT_W-1:0] DRAIN_LOAD   = CNT_W'(DRAIN_MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] GUARD_LOAD   = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [3:0] async_in;
    logic [3:0] sync_out;
    logic       req_s, busy_s, usb_rx_s, esc_rx_s;
    logic       activity;

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rx_prev_q, rx_prev_d;
    line_ctrl_t       lines_q, lines_d;
    logic             timeout_pulse_q, timeout_pulse_d;
    logic             timed_out_q, timed_out_d;

    // Idle levels: request and busy low, both RX lines high.
    assign async_in = {i_esc_rx, i_usb_rx, i_dshot_busy, i_req_passthrough};

    sync_2ff #(
        .WIDTH   (4),
        .RST_VAL (4'b1100)
    ) u_sync (
        .i_clk         (i_clk),
        .por_reset_27m (por_reset_27m),
        .i_async       (async_in),
        .o_sync        (sync_out)
    );

    assign {esc_rx_s, usb_rx_s, busy_s, req_s} = sync_out;

    // A start bit (high-to-low) on either UART line keeps the passthrough alive.
    assign rx_prev_d = {esc_rx_s, usb_rx_s};
    assign activity  = |(rx_prev_q & ~rx_prev_d);

    // Next-state, shared down-counter and registered output decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d         = state_q;
        cnt_d           = cnt_q;
        timeout_pulse_d = 1'b0;

        case (state_q)
            ST_DSHOT: begin
                if (req_s && !timed_out_q) begin
                    state_d = ST_DRAIN;
                    cnt_d   = DRAIN_LOAD;
                end
            end
            ST_DRAIN: begin
                if (!req_s) begin
                    state_d = ST_DSHOT;
                    cnt_d   = '0;
                end else if (!busy_s || cnt_q == '0) begin
                    state_d = ST_GUARD_PT;
                    cnt_d   = GUARD_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GUARD_PT: begin
                if (!req_s) begin
                    state_d = ST_GUARD_DS;
                    cnt_d   = GUARD_LOAD;
                end else if (cnt_q == '0) begin
                    state_d = ST_PASSTHRU;
                    cnt_d   = TIMEOUT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PASSTHRU: begin
                if (!req_s) begin
                    state_d = ST_GUARD_DS;
                    cnt_d   = GUARD_LOAD;
                end else if (activity) begin
                    cnt_d = TIMEOUT_LOAD;
                end else if (cnt_q == '0) begin
                    state_d         = ST_GUARD_DS;
                    cnt_d           = GUARD_LOAD;
                    timeout_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_GUARD_DS: begin
                if (cnt_q == '0) begin
                    state_d = ST_DSHOT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_GUARD_DS;
                cnt_d   = GUARD_LOAD;
            end
        endcase

        // Sticky until the host drops its request.
        timed_out_d = req_s ? (timed_out_q | timeout_pulse_d) : 1'b0;
        lines_d     = decode_lines(state_d);
    end

    // State, counter, edge-detect history and registered outputs.
    always_ff @(posedge i_clk or posedge por_reset_27m) begin
        if (por_reset_27m) begin
            state_q         <= ST_DSHOT;
            cnt_q           <= '0;
            rx_prev_q       <= 2'b11;
            lines_q         <= LINES_DSHOT;
            timeout_pulse_q <= 1'b0;
            timed_out_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rx_prev_q       <= rx_prev_d;
            lines_q         <= lines_d;
            timeout_pulse_q <= timeout_pulse_d;
            timed_out_q     <= timed_out_d;
        end
    end

    assign o_mux_sel       = lines_q.mux_sel;
    assign o_dshot_enable  = lines_q.dshot_enable;
    assign o_bridge_enable = lines_q.bridge_enable;
    assign o_hold_high     = lines_q.hold_high;
    assign o_state         = state_q;
    assign o_timeout_pulse = timeout_pulse_q;
    assign o_timed_out     = timed_out_q;

endmodule

// File: tb/tb_motor_line_sequencer.sv
// Randomized bench for motor_line_sequencer: expected phase lengths are derived
// from the handover rules (sync latency, drain limit, guard and timeout lengths).
module tb_motor_line_sequencer;

    localparam int GUARD     = 8;
    localparam int DRAIN_MAX = 20;
    localparam int TIMEOUT   = 50;
    localparam int SYNC_LAT  = 3;   // input change to state-register action, in clocks

    localparam int S_DSHOT    = 0;
    localparam int S_DRAIN    = 1;
    localparam int S_GUARD_PT = 2;
    localparam int S_PASSTHRU = 3;
    localparam int S_GUARD_DS = 4;

    logic       i_clk = 1'b0;
    logic       por_reset_27m;
    logic       req, busy, usb_rx, esc_rx;
    logic       o_mux_sel, o_dshot_enable, o_bridge_enable, o_hold_high;
    logic [2:0] o_state;
    logic       o_timeout_pulse, o_timed_out;

    int vectors     = 0;
    int miscompares = 0;

    // Cycle bookkeeping and scheduled stimulus.
    int t           = 0;
    int busy_drop_t = -1;
    int act_left    = 0;
    int act_next    = 0;
    int act_period  = 1;
    bit act_on_esc  = 1'b0;
    bit bridge_seen = 1'b0;

    always #5 i_clk = ~i_clk;

    motor_line_sequencer #(
        .GUARD_CYCLES     (GUARD),
        .DRAIN_MAX_CYCLES (DRAIN_MAX),
        .TIMEOUT_CYCLES   (TIMEOUT)
    ) dut (
        .i_clk             (i_clk),
        .por_reset_27m     (por_reset_27m),
        .i_req_passthrough (req),
        .i_dshot_busy      (busy),
        .i_usb_rx          (usb_rx),
        .i_esc_rx          (esc_rx),
        .o_mux_sel         (o_mux_sel),
        .o_dshot_enable    (o_dshot_enable),
        .o_bridge_enable   (o_bridge_enable),
        .o_hold_high       (o_hold_high),
        .o_state           (o_state),
        .o_timeout_pulse   (o_timeout_pulse),
        .o_timed_out       (o_timed_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0d)", tag, got, exp, t);
        end
    endtask

    // {mux_sel, dshot_enable, bridge_enable, hold_high} each state must present.
    function automatic logic [3:0] lines_for(input int st);
        case (st)
            S_DSHOT:    return 4'b1100;
            S_DRAIN:    return 4'b1000;
            S_PASSTHRU: return 4'b0010;
            default:    return 4'b0001;
        endcase
    endfunction

    task automatic check_lines(input string tag, input int st);
        check(tag, 32'({o_mux_sel, o_dshot_enable, o_bridge_enable, o_hold_high}), 32'(lines_for(st)));
    endtask

    // One clock: outputs sampled on the falling edge, then scheduled inputs applied.
    task automatic step();
        @(negedge i_clk);
        t++;
        if (t == busy_drop_t) busy = 1'b0;
        if (act_left > 0 && t == act_next) begin
            if (act_on_esc) esc_rx = 1'b0;
            else            usb_rx = 1'b0;
            act_left--;
            act_next += act_period;
        end else begin
            usb_rx = 1'b1;
            esc_rx = 1'b1;
        end
        if (o_bridge_enable) bridge_seen = 1'b1;
    endtask

    // Count consecutive cycles spent in a state (bounded).
    task automatic measure(input int st, output int n);
        n = 0;
        while (int'(o_state) == st && n < 1000) begin
            step();
            n++;
        end
    endtask

    // Called on the first GUARD_DS cycle; follows it back to DSHOT.
    task automatic through_guard_ds();
        int n;
        check_lines("guard_ds_lines", S_GUARD_DS);
        step();
        check("pulse_one_cycle", 32'(o_timeout_pulse), 0);
        measure(S_GUARD_DS, n);
        check("guard_ds_len", n + 1, GUARD);
        check("back_to_dshot", 32'(o_state), S_DSHOT);
        check_lines("dshot_lines", S_DSHOT);
    endtask

    // Raise req from idle DSHOT; busy stays high for b cycles (0 = never).
    // drop_j >= 0 drops req on that cycle of GUARD_PT, otherwise run into PASSTHRU.
    task automatic enter(input int b, input int drop_j);
        int n;
        int exp_drain;
        bridge_seen = 1'b0;
        req         = 1'b1;
        busy        = (b > 0);
        busy_drop_t = t + b;
        step();
        step();
        check("sync_latency_idle", 32'(o_state), S_DSHOT);
        step();
        check("drain_entry", 32'(o_state), S_DRAIN);
        check_lines("drain_lines", S_DRAIN);
        exp_drain = (b < 1) ? 1 : ((b > DRAIN_MAX) ? DRAIN_MAX : b);
        measure(S_DRAIN, n);
        check("drain_len", n, exp_drain);
        check("guard_pt_entry", 32'(o_state), S_GUARD_PT);
        check_lines("guard_pt_lines", S_GUARD_PT);
        if (drop_j >= 0) begin
            repeat (drop_j) step();
            req = 1'b0;
            measure(S_GUARD_PT, n);
            check("guard_pt_abort_len", drop_j + n, drop_j + SYNC_LAT);
            check("abort_to_guard_ds", 32'(o_state), S_GUARD_DS);
            through_guard_ds();
            check("no_bridge_on_abort", 32'(bridge_seen), 0);
        end else begin
            measure(S_GUARD_PT, n);
            check("guard_pt_len", n, GUARD);
            check("pt_entry", 32'(o_state), S_PASSTHRU);
            check_lines("pt_lines", S_PASSTHRU);
        end
        busy        = 1'b0;
        busy_drop_t = -1;
    endtask

    // In PASSTHRU: k activity pulses every 'period' cycles, then silence until timeout.
    task automatic pt_timeout(input int k, input int period, input bit on_esc);
        int n;
        act_left   = k;
        act_period = period;
        act_next   = t + period;
        act_on_esc = on_esc;
        measure(S_PASSTHRU, n);
        check("pt_activity_len", n, (k == 0) ? TIMEOUT : k * period + TIMEOUT + SYNC_LAT);
        check("timeout_to_guard_ds", 32'(o_state), S_GUARD_DS);
        check("timeout_pulse", 32'(o_timeout_pulse), 1);
        check("timed_out_set", 32'(o_timed_out), 1);
        through_guard_ds();
        repeat (20) step();
        check("timed_out_blocks_req", 32'(o_state), S_DSHOT);
        check("timed_out_held", 32'(o_timed_out), 1);
        req = 1'b0;
        step();
        step();
        check("timed_out_sync_hold", 32'(o_timed_out), 1);
        step();
        check("timed_out_clear", 32'(o_timed_out), 0);
    endtask

    // In PASSTHRU: drop req after w cycles, no activity.
    task automatic pt_drop(input int w);
        int n;
        act_left = 0;
        repeat (w) step();
        req = 1'b0;
        measure(S_PASSTHRU, n);
        check("pt_drop_len", w + n, w + SYNC_LAT);
        check("pt_drop_to_guard_ds", 32'(o_state), S_GUARD_DS);
        check("pt_drop_no_pulse", 32'(o_timeout_pulse), 0);
        check("pt_drop_no_flag", 32'(o_timed_out), 0);
        through_guard_ds();
    endtask

    // busy stuck high; req dropped w cycles into DRAIN returns straight to DSHOT.
    task automatic drain_drop(input int w);
        int n;
        req         = 1'b1;
        busy        = 1'b1;
        busy_drop_t = -1;
        repeat (SYNC_LAT) step();
        check("drain_drop_entry", 32'(o_state), S_DRAIN);
        repeat (w) step();
        req = 1'b0;
        measure(S_DRAIN, n);
        check("drain_drop_len", w + n, w + SYNC_LAT);
        check("drain_drop_to_dshot", 32'(o_state), S_DSHOT);
        check_lines("drain_drop_lines", S_DSHOT);
        busy = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached at t=%0d", t);
        $fatal(1, "watchdog");
    end

    initial begin
        por_reset_27m = 1'b1;
        req           = 1'b0;
        busy          = 1'b0;
        usb_rx        = 1'b1;
        esc_rx        = 1'b1;
        #1;
        check("rst_state", 32'(o_state), S_DSHOT);
        check_lines("rst_lines", S_DSHOT);
        check("rst_pulse", 32'(o_timeout_pulse), 0);
        check("rst_timed_out", 32'(o_timed_out), 0);
        step();
        step();
        por_reset_27m = 1'b0;
        repeat (3) step();
        check("idle_dshot", 32'(o_state), S_DSHOT);

        // Full handovers with activity-driven timeouts; first three fixed, rest random.
        for (int s = 0; s < 7; s++) begin
            int b, k, p;
            case (s)
                0:       begin b = 0;  k = 2; p = 30; end
                1:       begin b = 10; k = 1; p = 30; end
                2:       begin b = 26; k = 0; p = 10; end
                default: begin
                    b = int'($urandom_range(0, 26));
                    k = int'($urandom_range(0, 3));
                    p = int'($urandom_range(10, 45));
                end
            endcase
            enter(b, -1);
            pt_timeout(k, p, 1'($urandom_range(0, 1)));
        end

        // Aborts during GUARD_PT, including the last cycle that still aborts.
        for (int s = 0; s < 4; s++) begin
            int j;
            j = (s == 0) ? 4 : ((s == 1) ? 5 : int'($urandom_range(0, 5)));
            enter(int'($urandom_range(0, 5)), j);
        end

        // Request withdrawn mid-PASSTHRU, including right at the timeout boundary.
        for (int s = 0; s < 4; s++) begin
            int w;
            w = (s == 0) ? 47 : int'($urandom_range(0, 47));
            enter(int'($urandom_range(0, 5)), -1);
            pt_drop(w);
        end

        // Request withdrawn during DRAIN.
        drain_drop(17);
        drain_drop(int'($urandom_range(0, 16)));

        // Asynchronous reset in the middle of PASSTHRU.
        enter(0, -1);
        repeat (10) step();
        #2;
        por_reset_27m = 1'b1;
        #1;
        check("async_rst_state", 32'(o_state), S_DSHOT);
        check_lines("async_rst_lines", S_DSHOT);
        check("async_rst_flag", 32'(o_timed_out), 0);
        req  = 1'b0;
        busy = 1'b0;
        step();
        step();
        por_reset_27m = 1'b0;
        repeat (5) step();
        check("post_rst_idle", 32'(o_state), S_DSHOT);
        check_lines("post_rst_lines", S_DSHOT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
